// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit path
// Purpose: state encoding for uart_tx_fsm, parity-type constants and the
//          bit-counter width helper used by the serializer.
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Counter must hold DATA_WIDTH-1 (4 for 5-bit words up to 8 for 9-bit words).
  function automatic int cnt_width(input int data_width);
    return (data_width > 1) ? $clog2(data_width) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// rtl/uart_tx_fsm_if.sv - host write port of the UART transmitter
// Purpose: groups the host-side request/status signals.
// Ports:   P_DATA (word), DATA_VALID (send request), PAR_TYP (0 even, 1 odd),
//          BUSY (frame latched or in flight), TX_DONE (1-CLK end-of-frame pulse).
//          master = host side, slave = transmitter side.
interface uart_tx_fsm_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_TYP;
  logic                  BUSY;
  logic                  TX_DONE;

  modport master (
    output P_DATA, DATA_VALID, PAR_TYP,
    input  BUSY, TX_DONE
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_TYP,
    output BUSY, TX_DONE
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - load/shift register and bit counter for the TX frame
// Purpose: holds the latched word, presents the next data bit on bit_out and
//          flags when the last data bit is on the line.
// Ports:   CLK, RST (sync, active high); load latches data and clears the
//          counter; shift moves the register right by one; count advances
//          the bit counter; bit_out = next bit to drive; last = counter at
//          DATA_WIDTH-1.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  count,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  bit_out,
  output logic                  last
);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      bit_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= data;
      bit_cnt <= '0;
    end else begin
      if (shift) sreg    <= sreg >> 1;
      if (count) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign bit_out = sreg[0];
  // bit_cnt is the index of the data bit currently on the line.
  assign last    = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit FSM: START, DATA (LSB first), [PARITY], STOP
// Purpose: accepts one word from the host port and serialises it on TX_OUT,
//          advancing one bit per TX_tick pulse.
// Ports:   CLK, RST (sync, active high), TX_tick (bit-period strobe),
//          TX_OUT (registered serial line, idles high),
//          host (uart_tx_fsm_if.slave: P_DATA, DATA_VALID, PAR_TYP, BUSY, TX_DONE).
// Config:  UART_TX_PARITY_EN defined -> parity bit sent after the data bits;
//          undefined -> no parity bit, PAR_TYP ignored.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          TX_tick,
  output logic          TX_OUT,
  uart_tx_fsm_if.slave  host
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  tx_state_e state, state_nxt;
  logic      tx_line, tx_nxt;
  logic      busy_r, done_r;
  logic      load, shift, count;
  logic      bit_out, last;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_ser (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load),
    .shift   (shift),
    .count   (count),
    .data    (host.P_DATA),
    .bit_out (bit_out),
    .last    (last)
  );

`ifdef UART_TX_PARITY_EN
  // Parity is fixed at accept time so later host changes cannot touch the frame.
  logic par_bit;
  always_ff @(posedge CLK) begin
    if (RST)       par_bit <= 1'b0;
    else if (load) par_bit <= (^host.P_DATA) ^ host.PAR_TYP;
  end
`endif

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      tx_line <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_line <= tx_nxt;
      busy_r  <= (state_nxt != IDLE);
      done_r  <= (state == STOP) && TX_tick;
    end
  end

  // Next state. A tick in the accept cycle is ignored because IDLE only
  // looks at DATA_VALID.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (host.DATA_VALID) state_nxt = ARMED;
      ARMED:  if (TX_tick)         state_nxt = START;
      START:  if (TX_tick)         state_nxt = DATA;
      DATA: begin
        if (TX_tick && last) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (TX_tick)         state_nxt = STOP;
`endif
      STOP:   if (TX_tick)         state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Line value and serializer strobes.
  always_comb begin
    tx_nxt = tx_line;
    load   = 1'b0;
    shift  = 1'b0;
    count  = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        load   = host.DATA_VALID;
      end
      ARMED: if (TX_tick) tx_nxt = 1'b0;
      START: begin
        // d[0] goes out; shifting leaves d[1] ready for the first DATA tick.
        if (TX_tick) begin
          tx_nxt = bit_out;
          shift  = 1'b1;
        end
      end
      DATA: begin
        if (TX_tick) begin
          if (last) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt = par_bit;
`else
            tx_nxt = 1'b1;
`endif
          end else begin
            tx_nxt = bit_out;
            shift  = 1'b1;
            count  = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (TX_tick) tx_nxt = 1'b1;
`endif
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  assign TX_OUT       = tx_line;
  assign host.BUSY    = busy_r;
  assign host.TX_DONE = done_r;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - directed self-checking bench for uart_tx_fsm
module tb_uart_tx_fsm;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  // Expected frames as {stop, parity, data, start}; bit i is driven at tick i+1.
  localparam logic [11:0] EXP_A5_EVEN = 12'b0_1_0_10100101_0;
  localparam logic [11:0] EXP_A5_ODD  = 12'b0_1_1_10100101_0;
  localparam logic [11:0] EXP_3C      = 12'b0_1_0_00111100_0;
  localparam logic [11:0] EXP_FF_ODD  = 12'b0_1_1_11111111_0;
  localparam logic [11:0] EXP_81      = 12'b0_1_0_10000001_0;
`else
  localparam int NB = 10;
  // Expected frames as {stop, data, start}; bit i is driven at tick i+1.
  localparam logic [11:0] EXP_A5_EVEN = 12'b00_1_10100101_0;
  localparam logic [11:0] EXP_A5_ODD  = 12'b00_1_10100101_0;
  localparam logic [11:0] EXP_3C      = 12'b00_1_00111100_0;
  localparam logic [11:0] EXP_FF_ODD  = 12'b00_1_11111111_0;
  localparam logic [11:0] EXP_81      = 12'b00_1_10000001_0;
`endif

  logic CLK = 1'b0;
  logic RST;
  logic TX_tick;
  logic TX_OUT;
  int   checks = 0;
  int   errors = 0;

  uart_tx_fsm_if #(.DATA_WIDTH(8)) host_if ();

  uart_tx_fsm #(.DATA_WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TX_tick (TX_tick),
    .TX_OUT  (TX_OUT),
    .host    (host_if)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Two quiet cycles, then a one-cycle tick; returns at the negedge after it.
  task automatic tick();
    repeat (2) @(negedge CLK);
    TX_tick = 1'b1;
    @(negedge CLK);
    TX_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] data, input logic ptyp);
    @(negedge CLK);
    host_if.P_DATA     = data;
    host_if.PAR_TYP    = ptyp;
    host_if.DATA_VALID = 1'b1;
    @(negedge CLK);
    host_if.DATA_VALID = 1'b0;
    chk("accept_busy", host_if.BUSY, 1'b1);
    chk("accept_line", TX_OUT, 1'b1);
  endtask

  // Plays a whole frame already accepted; inject raises a new 0xFF odd-parity
  // request after tick 4 and keeps it asserted.
  task automatic run_frame(input string tag, input logic [11:0] exp, input bit inject);
    for (int i = 0; i < NB; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i + 1), TX_OUT, exp[i]);
      chk($sformatf("%s_busy%0d", tag, i + 1), host_if.BUSY, 1'b1);
      chk($sformatf("%s_nodone%0d", tag, i + 1), host_if.TX_DONE, 1'b0);
      if (inject && i == 3) begin
        host_if.P_DATA     = 8'hFF;
        host_if.PAR_TYP    = PAR_ODD;
        host_if.DATA_VALID = 1'b1;
      end
    end
    tick();
    chk({tag, "_done"}, host_if.TX_DONE, 1'b1);
    chk({tag, "_idle_busy"}, host_if.BUSY, 1'b0);
    chk({tag, "_idle_line"}, TX_OUT, 1'b1);
    @(negedge CLK);
    chk({tag, "_done_pulse"}, host_if.TX_DONE, 1'b0);
  endtask

  initial begin
    RST                = 1'b1;
    TX_tick            = 1'b0;
    host_if.P_DATA     = 8'h00;
    host_if.DATA_VALID = 1'b0;
    host_if.PAR_TYP    = PAR_EVEN;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_line", TX_OUT, 1'b1);
    chk("reset_busy", host_if.BUSY, 1'b0);
    chk("reset_done", host_if.TX_DONE, 1'b0);

    // Tick with nothing pending keeps the line idle.
    tick();
    chk("idle_tick_line", TX_OUT, 1'b1);
    chk("idle_tick_busy", host_if.BUSY, 1'b0);

    send(8'hA5, PAR_EVEN);
    run_frame("a5_even", EXP_A5_EVEN, 1'b0);

    send(8'hA5, PAR_ODD);
    run_frame("a5_odd", EXP_A5_ODD, 1'b0);

    // Request while busy is ignored; a held request is taken right after TX_DONE.
    send(8'h3C, PAR_EVEN);
    run_frame("busy_3c", EXP_3C, 1'b1);
    chk("b2b_accept_busy", host_if.BUSY, 1'b1);
    host_if.DATA_VALID = 1'b0;
    run_frame("b2b_ff", EXP_FF_ODD, 1'b0);
    host_if.PAR_TYP = PAR_EVEN;

    // Accept and tick in the same cycle: the tick is not consumed.
    @(negedge CLK);
    host_if.P_DATA     = 8'h81;
    host_if.DATA_VALID = 1'b1;
    TX_tick            = 1'b1;
    @(negedge CLK);
    host_if.DATA_VALID = 1'b0;
    TX_tick            = 1'b0;
    chk("simul_line", TX_OUT, 1'b1);
    chk("simul_busy", host_if.BUSY, 1'b1);
    run_frame("simul_81", EXP_81, 1'b0);

    // Reset while data bit 3 is on the line.
    send(8'h3C, PAR_EVEN);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_d3", TX_OUT, 1'b1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_line", TX_OUT, 1'b1);
    chk("rst_mid_busy", host_if.BUSY, 1'b0);
    chk("rst_mid_done", host_if.TX_DONE, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rst_quiet_line%0d", i), TX_OUT, 1'b1);
      chk($sformatf("rst_quiet_done%0d", i), host_if.TX_DONE, 1'b0);
    end
    send(8'hA5, PAR_EVEN);
    run_frame("post_rst_a5", EXP_A5_EVEN, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
